// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the M-stage memory access unit: load/store type codes,
// bus size codes and the handshake state machine states.
package mem_access_unit_pkg;

    localparam logic [7:0] LB  = 8'hE0;
    localparam logic [7:0] LBU = 8'hE1;
    localparam logic [7:0] LH  = 8'hE2;
    localparam logic [7:0] LHU = 8'hE3;
    localparam logic [7:0] LW  = 8'hE4;
    localparam logic [7:0] SB  = 8'hE5;
    localparam logic [7:0] SH  = 8'hE6;
    localparam logic [7:0] SW  = 8'hE7;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateT;

    // Unknown codes fall into word size; they never reach the bus anyway.
    function automatic logic [1:0] sizeOf(input logic [7:0] code);
        case (code)
            LB, LBU, SB: sizeOf = SZ_B;
            LH, LHU, SH: sizeOf = SZ_H;
            default:     sizeOf = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_fmt.sv
// Byte-lane formatting: store replication and byte enables, plus load lane
// select with sign/zero extension.
module mem_lane_fmt
    import mem_access_unit_pkg::*;
(
    input  logic [7:0]  alucontrol,
    input  logic [1:0]  addrLo,
    input  logic [31:0] storeData,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] loadData
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel  = rdata[{addrLo, 3'b000} +: 8];
        halfSel  = addrLo[1] ? rdata[31:16] : rdata[15:0];
        wstrb    = 4'b0000;
        wdata    = '0;
        loadData = '0;
        case (alucontrol)
            SB: begin
                wstrb = 4'b0001 << addrLo;
                wdata = {4{storeData[7:0]}};
            end
            SH: begin
                wstrb = addrLo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{storeData[15:0]}};
            end
            SW: begin
                wstrb = 4'b1111;
                wdata = storeData;
            end
            LB:      loadData = {{24{byteSel[7]}}, byteSel};
            LBU:     loadData = {24'd0, byteSel};
            LH:      loadData = {{16{halfSel[15]}}, halfSel};
            LHU:     loadData = {16'd0, halfSel};
            LW:      loadData = rdata;
            default: loadData = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage memory access unit: one SRAM-like bus transaction per load/store,
// with stall request, alignment exceptions and flush draining.
//
// state | meaning
// IDLE  | no access outstanding; a valid M instruction issues its request now
// REQ   | request presented, waiting for data_addr_ok
// WAIT  | request accepted, waiting for data_data_ok
// DONE  | result in readdataM; held while the hazard unit still stalls M
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memenM,
    input  logic          memwriteM,
    input  logic [7:0]    alucontrolM,
    input  logic          stallM,
    input  logic          flushM,
    input  logic [AW-1:0] aluoutM,
    input  logic [DW-1:0] writedataM,
    output logic [DW-1:0] readdataM,
    output logic          stallreqM,
    output logic          adelM,
    output logic          adesM,
    output logic [AW-1:0] badvaddrM,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [3:0]    data_wstrb,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata
);

    stateT         state;
    logic          dropFlag;
    logic [DW-1:0] readReg;

    logic          isLoad, isStore, codeOk, misaligned, addrErr, start, reqActive;
    logic [1:0]    size;
    logic [3:0]    fmtStrb;
    logic [31:0]   fmtWdata, fmtLoad;

    mem_lane_fmt uLaneFmt (
        .alucontrol (alucontrolM),
        .addrLo     (aluoutM[1:0]),
        .storeData  (writedataM),
        .rdata      (data_rdata),
        .wstrb      (fmtStrb),
        .wdata      (fmtWdata),
        .loadData   (fmtLoad)
    );

    // Gating with rst keeps every output quiet for the whole reset pulse,
    // even while the M-stage inputs still present an instruction.
    always_comb begin
        isLoad     = ~memwriteM & (alucontrolM inside {LB, LBU, LH, LHU, LW});
        isStore    = memwriteM & (alucontrolM inside {SB, SH, SW});
        codeOk     = memenM & (isLoad | isStore);
        size       = sizeOf(alucontrolM);
        misaligned = ((size == SZ_H) & aluoutM[0]) | ((size == SZ_W) & (|aluoutM[1:0]));
        addrErr    = ~rst & codeOk & misaligned;
        start      = ~rst & (state == IDLE) & codeOk & ~misaligned & ~flushM;
        reqActive  = start | (state == REQ);
    end

    assign adelM      = addrErr & isLoad;
    assign adesM      = addrErr & isStore;
    assign badvaddrM  = addrErr ? aluoutM : '0;
    assign stallreqM  = start | (state == REQ) | (state == WAIT);
    assign data_req   = reqActive;
    assign data_wr    = reqActive & memwriteM;
    assign data_size  = reqActive ? size : 2'd0;
    assign data_addr  = !reqActive ? '0
                      : (size == SZ_W) ? {aluoutM[AW-1:2], 2'b00} : aluoutM;
    assign data_wstrb = reqActive ? fmtStrb : 4'b0000;
    assign data_wdata = reqActive ? fmtWdata : '0;
    assign readdataM  = readReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dropFlag <= 1'b0;
            readReg  <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= data_addr_ok ? WAIT : REQ;
                REQ: begin
                    if (flushM)       dropFlag <= 1'b1;
                    if (data_addr_ok) state    <= WAIT;
                end
                WAIT: begin
                    if (flushM) dropFlag <= 1'b1;
                    if (data_data_ok) begin
                        dropFlag <= 1'b0;
                        // A killed access still drains on the bus, but its data is discarded.
                        if (dropFlag | flushM) begin
                            state <= IDLE;
                        end else begin
                            state   <= DONE;
                            readReg <= memwriteM ? '0 : fmtLoad;
                        end
                    end
                end
                DONE:    if (!stallM) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    reqAckExclusive: assert property (@(posedge clk) disable iff (rst)
        !((state == REQ) && data_addr_ok && data_data_ok));

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage responder for the load/store controls that the pipeline controller issues: memenM, memwriteM and alucontrolM.
- Turns each M-stage memory instruction into one transaction on the SRAM-like data bus. Generates byte enables and store-data replication, then sign- or zero-extends the load result.
- Requests a pipeline stall until the transaction completes and flags misaligned addresses.
- Sits between the datapath M stage, the hazard unit (which consumes stallreqM) and the data-side bus bridge.

Parameters:
- AW, 32, address width.
- DW, 32, data width (fixed 32; byte lanes = DW/8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- memenM  in  1  memory instruction present in M.
- memwriteM  in  1  1 = store, 0 = load.
- alucontrolM  in  8  load/store type code (package constants).
- stallM  in  1  M stage held by hazard unit.
- flushM  in  1  M-stage instruction is being killed.
- aluoutM  in  AW  effective address.
- writedataM  in  DW  rt value for stores.
- readdataM  out  DW  extended load result, valid while state==DONE.
- stallreqM  out  1  stall request to hazard unit.
- adelM  out  1  load address error.
- adesM  out  1  store address error.
- badvaddrM  out  AW  faulting address (= aluoutM when adelM|adesM, else 0).
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_size  out  2  0=byte, 1=half, 2=word.
- data_addr  out  AW  aluoutM with low 2 bits forced to 0 for word.
- data_wstrb  out  4  byte enables.
- data_wdata  out  DW  store data, replicated into lanes.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  read data valid / write done.
- data_rdata  in  DW  read data.

Behaviour:
- Reset (async): state=IDLE, readdata register=0.
  - All outputs are derived from state and inputs. With memenM=0 they are 0.
- Type codes:
  - Loads: LB=8'hE0, LBU=E1, LH=E2, LHU=E3, LW=E4.
  - Stores: SB=E5, SH=E6, SW=E7.
  - Any other code with memenM=1 is treated as no access.
- Alignment check, combinational:
  - Half access requires addr[0]=0; word access requires addr[1:0]=0.
  - A violation raises adelM (load) or adesM (store) the same cycle.
  - On a violation: no bus request, stallreqM=0, FSM stays IDLE.
- Byte enables:
  - SB → 4'b0001<<addr[1:0], wdata={4{b}}.
  - SH → addr[1]?1100:0011, wdata={2{h}}.
  - SW → 1111.
  - Loads → wstrb=0.
- FSM states and transitions:
  - IDLE: start = memenM & valid code & ~addr_err & ~flushM.
    - data_req = start.
    - If start & data_addr_ok → WAIT.
    - If start & ~data_addr_ok → REQ.
  - REQ: data_req=1, and address/size/wdata held from the M inputs (M is stalled).
    - data_addr_ok → WAIT.
  - WAIT: data_req=0.
    - data_data_ok → capture the lane-selected, extended data_rdata into readdata (stores capture 0).
    - Then go to DONE, or to IDLE if the access is being dropped.
  - DONE: readdataM valid, stallreqM=0.
    - Leave for IDLE on the first cycle with ~stallM.
    - Remain in DONE while stallM=1, so the result is held and the access is not reissued.
- stallreqM = start | state==REQ | state==WAIT.
- Latency: minimum 2 cycles of stall when addr_ok and data_ok come on consecutive cycles; readdataM is valid in the third cycle.
- Flush mid-operation:
  - flushM in IDLE suppresses the request.
  - flushM in REQ keeps req until accepted, because the bus protocol forbids withdrawing a request.
  - flushM in REQ or WAIT sets a drop flag. The access completes on the bus, the data is discarded, and the FSM returns to IDLE, skipping DONE.
  - stallreqM stays high until the drain finishes, so the next M instruction cannot start on an outstanding bus.
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
- Simultaneous addr_ok and data_ok in REQ is illegal on this bus and must be asserted against in simulation.

Decomposition:
- Shared package: memory type codes (LB…SW), size encodings (SZ_B/H/W), and state enum (IDLE, REQ, WAIT, DONE).
- One sub-module, mem_lane_fmt (combinational): performs store lane replication and wstrb on the store side, and lane select plus sign/zero extension on the load side.
- The FSM stays in mem_access_unit.

Test Plan:
1. LW at 0x1000_0004, addr_ok same cycle, data_ok next cycle with rdata=0xDEAD_BEEF.
   → stallreqM high 2 cycles; readdataM=0xDEADBEEF in DONE; data_size=2.
2. LB at 0x...0003 with rdata=0x80FF_FFFF → readdataM=0xFFFF_FF80.
   Repeat as LBU → 0x0000_0080.
3. SH at 0x...0002 with writedataM=0x1234_ABCD → data_wstrb=1100, data_wdata=0xABCD_ABCD, data_wr=1.
4. LW at 0x...0002 → adelM=1, badvaddrM=0x...0002, data_req never asserted, stallreqM=0.
   Repeat with SW → adesM=1.
5. Hold data_addr_ok low 3 cycles, assert flushM in REQ.
   → data_req held until accepted, stallreqM high until data_ok, FSM returns to IDLE without DONE, readdataM unchanged.
6. Assert rst mid-WAIT → state=IDLE and all outputs 0 immediately, without waiting for a clock edge.
   After release, a new LW completes normally.
